// File: rtl/i2c_reg_pkg.sv
// Shared constants, region type and address decode for the I2C register bank.
package i2c_reg_pkg;

  localparam logic I2C_DIR_WRITE = 1'b0;
  localparam logic I2C_DIR_READ  = 1'b1;

  localparam int unsigned I2C_ERR_W  = 8;
  localparam int unsigned I2C_ADDR_W = 8;

  typedef enum logic [1:0] {
    RegRw,
    RegRo,
    RegStat,
    RegNone
  } reg_region_e;

  // Map a register address onto RW / RO / STAT / unmapped for a given layout.
  function automatic reg_region_e addr_region(input logic [I2C_ADDR_W-1:0] addr,
                                              input int unsigned           rw_len,
                                              input int unsigned           ro_len);
    int unsigned a;
    a = 32'(addr);
    if (a < rw_len)                 return RegRw;
    else if (a < rw_len + ro_len)   return RegRo;
    else if (a == rw_len + ro_len)  return RegStat;
    else                            return RegNone;
  endfunction

endpackage

// File: rtl/i2c_err_counter.sv
// Saturating event counter; clear wins over increment.
module i2c_err_counter
  import i2c_reg_pkg::*;
#(
  parameter int unsigned Width = I2C_ERR_W
) (
  input  logic             mod_clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge mod_clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind i2c_slave: RW bytes, snapshotted RO bytes and an error/status byte.
module i2c_reg_bank
  import i2c_reg_pkg::*;
#(
  parameter int unsigned            RW_LEN  = 10,
  parameter int unsigned            RO_LEN  = 3,
  parameter logic [RW_LEN*8-1:0]    RW_INIT = '0
) (
  input  logic                  mod_clk,
  input  logic                  rst_n,
  input  logic [I2C_ADDR_W-1:0] i2c_reg_addr,
  input  logic [7:0]            i2c_data_out,
  input  logic                  i2c_data_transfer_dir,
  input  logic                  i2c_data_transfer_done,
  output logic [7:0]            i2c_data_in,
  input  logic [RO_LEN*8-1:0]   ro_data,
  input  logic                  wp,
  output logic [RW_LEN*8-1:0]   rw_regs,
  output logic [RW_LEN-1:0]     rw_wr_pulse,
  output logic [I2C_ERR_W-1:0]  err_cnt
);

  // done_q resets high so a done held through reset release is not an event.
  logic                  done_q;
  logic [I2C_ADDR_W-1:0] addr_q;
  // Byte event captured on the edge that sees done rise; acted on one edge later.
  logic                  ev_q, ev_dir_q;
  logic [I2C_ADDR_W-1:0] ev_addr_q;
  logic [7:0]            ev_data_q;

  logic [RW_LEN*8-1:0]   rw_q, rw_d;
  logic [RW_LEN-1:0]     pulse_q, pulse_d;
  logic [RO_LEN*8-1:0]   ro_snap_q, ro_snap_d;
  logic                  snap_valid_q;
  logic [7:0]            rdata_q, rdata_d;

  logic                  err_inc, err_clr;
  logic                  snap_load;

  // Edge detect and event capture.
  always_ff @(posedge mod_clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b1;
      addr_q    <= '0;
      ev_q      <= 1'b0;
      ev_dir_q  <= I2C_DIR_WRITE;
      ev_addr_q <= '0;
      ev_data_q <= '0;
    end else begin
      done_q    <= i2c_data_transfer_done;
      addr_q    <= i2c_reg_addr;
      ev_q      <= i2c_data_transfer_done & ~done_q;
      ev_dir_q  <= i2c_data_transfer_dir;
      ev_addr_q <= i2c_reg_addr;
      ev_data_q <= i2c_data_out;
    end
  end

  // Write decode: exactly one of update, reject-count or clear per write event.
  always_comb begin
    rw_d    = rw_q;
    pulse_d = '0;
    err_inc = 1'b0;
    err_clr = 1'b0;
    if (ev_q && (ev_dir_q == I2C_DIR_WRITE)) begin
      unique case (addr_region(ev_addr_q, RW_LEN, RO_LEN))
        RegRw: begin
          if (wp) begin
            err_inc = 1'b1;
          end else begin
            for (int unsigned k = 0; k < RW_LEN; k++) begin
              if (32'(ev_addr_q) == k) begin
                rw_d[k*8 +: 8] = ev_data_q;
                pulse_d[k]     = 1'b1;
              end
            end
          end
        end
        RegStat: err_clr = 1'b1;
        default: err_inc = 1'b1;
      endcase
    end
  end

  // Reload the snapshot until first valid, and whenever the address lands on the RO base.
  always_comb begin
    snap_load = !snap_valid_q ||
                ((32'(i2c_reg_addr) == RW_LEN) && (32'(addr_q) != RW_LEN));
    ro_snap_d = snap_load ? ro_data : ro_snap_q;
  end

  // Read mux from the live address; registered below.
  always_comb begin
    rdata_d = '0;
    unique case (addr_region(i2c_reg_addr, RW_LEN, RO_LEN))
      RegRw: begin
        for (int unsigned k = 0; k < RW_LEN; k++) begin
          if (32'(i2c_reg_addr) == k) rdata_d = rw_q[k*8 +: 8];
        end
      end
      RegRo: begin
        for (int unsigned k = 0; k < RO_LEN; k++) begin
          if (32'(i2c_reg_addr) == RW_LEN + k) rdata_d = ro_snap_q[k*8 +: 8];
        end
      end
      RegStat: rdata_d = err_cnt;
      default: rdata_d = '0;
    endcase
  end

  // Register state and read data.
  always_ff @(posedge mod_clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q         <= RW_INIT;
      pulse_q      <= '0;
      ro_snap_q    <= '0;
      snap_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      rw_q         <= rw_d;
      pulse_q      <= pulse_d;
      ro_snap_q    <= ro_snap_d;
      snap_valid_q <= 1'b1;
      rdata_q      <= rdata_d;
    end
  end

  i2c_err_counter #(
    .Width (I2C_ERR_W)
  ) u_err_counter (
    .mod_clk (mod_clk),
    .rst_n   (rst_n),
    .inc_i   (err_inc),
    .clr_i   (err_clr),
    .cnt_o   (err_cnt)
  );

  assign rw_regs     = rw_q;
  assign rw_wr_pulse = pulse_q;
  assign i2c_data_in = rdata_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Randomised self-checking bench for i2c_reg_bank against a byte-array reference model.
module tb_i2c_reg_bank;

  localparam int unsigned RW_LEN = 10;
  localparam int unsigned RO_LEN = 3;
  localparam int unsigned STAT   = RW_LEN + RO_LEN;
  localparam logic [RW_LEN*8-1:0] RW_INIT = 80'hA9B8_C7D6_E5F4_0312_0102;

  logic                 mod_clk = 1'b0;
  logic                 rst_n;
  logic [7:0]           i2c_reg_addr;
  logic [7:0]           i2c_data_out;
  logic                 i2c_data_transfer_dir;
  logic                 i2c_data_transfer_done;
  logic [7:0]           i2c_data_in;
  logic [RO_LEN*8-1:0]  ro_data;
  logic                 wp;
  logic [RW_LEN*8-1:0]  rw_regs;
  logic [RW_LEN-1:0]    rw_wr_pulse;
  logic [7:0]           err_cnt;

  i2c_reg_bank #(
    .RW_LEN  (RW_LEN),
    .RO_LEN  (RO_LEN),
    .RW_INIT (RW_INIT)
  ) dut (
    .mod_clk                (mod_clk),
    .rst_n                  (rst_n),
    .i2c_reg_addr           (i2c_reg_addr),
    .i2c_data_out           (i2c_data_out),
    .i2c_data_transfer_dir  (i2c_data_transfer_dir),
    .i2c_data_transfer_done (i2c_data_transfer_done),
    .i2c_data_in            (i2c_data_in),
    .ro_data                (ro_data),
    .wp                     (wp),
    .rw_regs                (rw_regs),
    .rw_wr_pulse            (rw_wr_pulse),
    .err_cnt                (err_cnt)
  );

  always #5 mod_clk = ~mod_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0] exp_rw [RW_LEN];
  int         exp_err;

  // Pulse monitor: total strobe cycles seen and the last non-zero strobe vector.
  int                pulse_total = 0;
  logic [RW_LEN-1:0] last_pulse  = '0;
  always @(negedge mod_clk) begin
    if (rw_wr_pulse !== '0) begin
      pulse_total++;
      last_pulse = rw_wr_pulse;
    end
  end

  function automatic logic [RW_LEN*8-1:0] model_rw();
    logic [RW_LEN*8-1:0] v;
    for (int k = 0; k < RW_LEN; k++) v[k*8 +: 8] = exp_rw[k];
    return v;
  endfunction

  task automatic model_reset();
    logic [RW_LEN*8-1:0] init;
    init = RW_INIT;
    for (int k = 0; k < RW_LEN; k++) exp_rw[k] = init[k*8 +: 8];
    exp_err = 0;
  endtask

  // One completed byte as seen by the register map.
  task automatic model_event(input int addr, input logic [7:0] data, input logic dir,
                             input logic wpv);
    if (dir) return;
    if (addr < RW_LEN && !wpv) exp_rw[addr] = data;
    else if (addr == STAT)     exp_err = 0;
    else                       exp_err = (exp_err < 255) ? exp_err + 1 : 255;
  endtask

  function automatic logic [7:0] model_read(input int addr);
    if (addr < RW_LEN) return exp_rw[addr];
    if (addr == STAT)  return 8'(exp_err);
    return 8'h00;
  endfunction

  // Full byte transfer with done held for 'hold' cycles; returns on a negedge.
  task automatic xfer(input int addr, input logic [7:0] data, input logic dir, input int hold);
    @(posedge mod_clk); #1;
    i2c_reg_addr          = 8'(addr);
    i2c_data_out          = data;
    i2c_data_transfer_dir = dir;
    @(posedge mod_clk); #1;
    i2c_data_transfer_done = 1'b1;
    repeat (hold) @(posedge mod_clk);
    #1 i2c_data_transfer_done = 1'b0;
    repeat (3) @(posedge mod_clk);
    @(negedge mod_clk);
    model_event(addr, data, dir, wp);
  endtask

  task automatic do_read(input int addr, output logic [7:0] val);
    @(posedge mod_clk); #1;
    i2c_reg_addr = 8'(addr);
    repeat (2) @(posedge mod_clk);
    @(negedge mod_clk);
    val = i2c_data_in;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    i2c_reg_addr = 8'd0; i2c_data_out = 8'd0; i2c_data_transfer_dir = 1'b0;
    i2c_data_transfer_done = 1'b0; ro_data = '0; wp = 1'b0;
    repeat (3) @(posedge mod_clk);
    @(negedge mod_clk);
    n_checks++;
    if (rw_regs !== RW_INIT) begin
      n_fail++; $display("FAIL reset_rw: got %h expected %h", rw_regs, RW_INIT);
    end
    n_checks++;
    if (err_cnt !== 8'd0 || rw_wr_pulse !== '0) begin
      n_fail++; $display("FAIL reset_err_pulse: got err=%h pulse=%b expected 0", err_cnt,
                         rw_wr_pulse);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (i2c_data_in !== 8'h00) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 00", i2c_data_in);
    end
    @(posedge mod_clk); #1;
    n_checks++;
    if (i2c_data_in !== 8'h02) begin
      n_fail++; $display("FAIL reset_byte0_read: got %h expected 02", i2c_data_in);
    end
  endtask

  task automatic test_write();
    int p0;
    logic [7:0] r;
    p0 = pulse_total;
    xfer(3, 8'h5A, 1'b0, 4);
    n_checks++;
    if (rw_regs !== model_rw() || rw_regs[31:24] !== 8'h5A) begin
      n_fail++; $display("FAIL write_byte3: got %h expected %h", rw_regs, model_rw());
    end
    n_checks++;
    if ((pulse_total - p0) != 1 || last_pulse !== 10'b0000001000) begin
      n_fail++; $display("FAIL write_pulse: got %0d cycles of %b expected 1 of 0000001000",
                         pulse_total - p0, last_pulse);
    end
    do_read(3, r);
    n_checks++;
    if (r !== 8'h5A) begin
      n_fail++; $display("FAIL write_readback: got %h expected 5a", r);
    end
  endtask

  task automatic test_wp();
    int p0;
    logic [7:0] b0;
    wp = 1'b0;
    xfer(STAT, 8'h00, 1'b0, 1);
    b0 = exp_rw[0];
    wp = 1'b1;
    p0 = pulse_total;
    xfer(0, 8'h77, 1'b0, 2);
    n_checks++;
    if (rw_regs[7:0] !== b0 || (pulse_total - p0) != 0 || err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL wp_reject: got byte0=%h pulses=%0d err=%0d expected %h 0 1",
                         rw_regs[7:0], pulse_total - p0, err_cnt, b0);
    end
    xfer(11, 8'h33, 1'b0, 1);
    n_checks++;
    if (err_cnt !== 8'd2) begin
      n_fail++; $display("FAIL wp_ro_write: got err=%0d expected 2", err_cnt);
    end
    xfer(STAT, 8'h99, 1'b0, 1);
    n_checks++;
    if (err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL wp_stat_clear: got err=%0d expected 0", err_cnt);
    end
    wp = 1'b0;
  endtask

  task automatic test_random_traffic();
    int a, p0, exp_p;
    logic [7:0] d, r;
    logic dir;
    for (int i = 0; i < 40; i++) begin
      a   = $urandom_range(0, 15);
      d   = 8'($urandom_range(0, 255));
      dir = ($urandom_range(0, 3) == 0);
      wp  = ($urandom_range(0, 3) == 0);
      exp_p = (!dir && a < RW_LEN && !wp) ? 1 : 0;
      p0 = pulse_total;
      xfer(a, d, dir, $urandom_range(1, 3));
      n_checks++;
      if (rw_regs !== model_rw() || err_cnt !== 8'(exp_err) || (pulse_total - p0) != exp_p) begin
        n_fail++;
        $display("FAIL rand_xfer%0d a=%0d dir=%0b wp=%0b: got rw=%h err=%0d pulses=%0d expected rw=%h err=%0d pulses=%0d",
                 i, a, dir, wp, rw_regs, err_cnt, pulse_total - p0, model_rw(), exp_err, exp_p);
      end
    end
    wp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(0, 14);
      if (a >= RW_LEN && a < STAT) a = 200;
      do_read(a, r);
      n_checks++;
      if (r !== model_read(a)) begin
        n_fail++; $display("FAIL rand_read a=%0d: got %h expected %h", a, r, model_read(a));
      end
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] r;
    logic [23:0] v;
    do_read(0, r);
    ro_data = 24'h000100;
    do_read(10, r);
    n_checks++;
    if (r !== 8'h00) begin n_fail++; $display("FAIL snap_rd10: got %h expected 00", r); end
    ro_data = 24'hFFFFFF;
    do_read(11, r);
    n_checks++;
    if (r !== 8'h01) begin n_fail++; $display("FAIL snap_rd11: got %h expected 01", r); end
    do_read(12, r);
    n_checks++;
    if (r !== 8'h00) begin n_fail++; $display("FAIL snap_rd12: got %h expected 00", r); end
    do_read(0, r);
    do_read(10, r);
    n_checks++;
    if (r !== 8'hFF) begin n_fail++; $display("FAIL snap_reenter: got %h expected ff", r); end
    for (int i = 0; i < 4; i++) begin
      v = 24'($urandom);
      ro_data = v;
      do_read(5, r);
      do_read(10, r);
      ro_data = 24'($urandom);
      n_checks++;
      if (r !== v[7:0]) begin
        n_fail++; $display("FAIL snap_rand%0d_b0: got %h expected %h", i, r, v[7:0]);
      end
      do_read(11, r);
      ro_data = 24'($urandom);
      n_checks++;
      if (r !== v[15:8]) begin
        n_fail++; $display("FAIL snap_rand%0d_b1: got %h expected %h", i, r, v[15:8]);
      end
      do_read(12, r);
      n_checks++;
      if (r !== v[23:16]) begin
        n_fail++; $display("FAIL snap_rand%0d_b2: got %h expected %h", i, r, v[23:16]);
      end
    end
  endtask

  task automatic test_saturate();
    int a;
    logic [7:0] r;
    wp = 1'b1;
    for (int i = 0; i < 260; i++) begin
      a = $urandom_range(0, 254);
      if (a >= STAT) a++;
      xfer(a, 8'($urandom), 1'b0, 1);
    end
    n_checks++;
    if (err_cnt !== 8'd255 || exp_err != 255) begin
      n_fail++; $display("FAIL sat_count: got %0d expected 255", err_cnt);
    end
    do_read(STAT, r);
    n_checks++;
    if (r !== 8'hFF) begin n_fail++; $display("FAIL sat_stat_read: got %h expected ff", r); end
    do_read(200, r);
    n_checks++;
    if (r !== 8'h00) begin n_fail++; $display("FAIL unmapped_read: got %h expected 00", r); end
    wp = 1'b0;
  endtask

  task automatic test_reset_done_high();
    int p0;
    @(posedge mod_clk); #1;
    i2c_reg_addr = 8'd4; i2c_data_out = 8'hEE; i2c_data_transfer_dir = 1'b0;
    i2c_data_transfer_done = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge mod_clk);
    #3 rst_n = 1'b1;
    p0 = pulse_total;
    repeat (4) @(posedge mod_clk);
    #1 i2c_data_transfer_done = 1'b0;
    repeat (3) @(posedge mod_clk);
    @(negedge mod_clk);
    n_checks++;
    if (rw_regs !== model_rw() || (pulse_total - p0) != 0 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_done_high: got rw=%h pulses=%0d err=%0d expected rw=%h 0 0",
                         rw_regs, pulse_total - p0, err_cnt, model_rw());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wp();
    test_random_traffic();
    test_snapshot();
    test_saturate();
    test_reset_done_high();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_bank.md
# i2c_reg_bank

Parametrised register bank between `i2c_slave` and user logic, replacing the fixed 10-byte RW / 3-byte RO map. It provides:
- a configurable RW byte array with per-byte reset values and one-cycle write strobes;
- a RO region taken from a coherent snapshot of user inputs;
- a global write-protect input;
- a saturating error counter, readable over I2C, that counts rejected writes.

## Interface
Parameters:
- `RW_LEN`, 10, number of RW bytes at addresses 0..RW_LEN-1
- `RO_LEN`, 3, number of RO bytes at addresses RW_LEN..RW_LEN+RO_LEN-1
- `RW_INIT`, 0, RW_LEN*8-bit reset image; byte k = bits [k*8+:8]
- Constraint: RW_LEN+RO_LEN+1 <= 256, RW_LEN >= 1, RO_LEN >= 1

Ports:
- `mod_clk`  in  1  module clock; the same clock that drives `i2c_slave`
- `rst_n`  in  1  asynchronous, active-low reset
- `i2c_reg_addr`  in  8  current register address from `i2c_slave`
- `i2c_data_out`  in  8  write byte from `i2c_slave`
- `i2c_data_transfer_dir`  in  1  0 = master write, 1 = master read
- `i2c_data_transfer_done`  in  1  high when a byte completes; may stay high for several cycles
- `i2c_data_in`  out  8  read byte to `i2c_slave`; registered
- `ro_data`  in  RO_LEN*8  user status; byte k = bits [k*8+:8]
- `wp`  in  1  write-protect; 1 rejects all RW writes
- `rw_regs`  out  RW_LEN*8  current RW contents
- `rw_wr_pulse`  out  RW_LEN  one-cycle strobe per written RW byte
- `err_cnt`  out  8  rejected-write count; saturates at 255

## Operation
- STAT address = RW_LEN+RO_LEN. Reads return `err_cnt`. Writes clear it.
- Byte event: rising edge of `i2c_data_transfer_done`, detected with `done_q`. `done_q` resets to 1, so `done` held high across reset release produces no event. A multi-cycle `done` high produces exactly one event.
- Write event (dir=0), decided by address:
  - addr < RW_LEN and wp=0: byte addr <= `i2c_data_out`; `rw_wr_pulse[addr]` = 1 for one cycle.
  - addr < RW_LEN and wp=1: no update, no pulse; `err_cnt`++.
  - RO region: ignored; `err_cnt`++.
  - addr == STAT: `err_cnt` <= 0. The clear is not counted and is allowed while wp=1.
  - addr > STAT: ignored; `err_cnt`++.
- Read event (dir=1): no state change.
- RO snapshot:
  - `ro_snap` loads from `ro_data` in any cycle where `snap_valid`=0 (after reset).
  - It also loads in any cycle where `i2c_reg_addr` == RW_LEN and `addr_q` != RW_LEN, i.e. the address has just moved to the RO base.
  - Otherwise it holds, so a sequential multi-byte RO read is coherent.
- Read mux, registered every cycle from the current address:
  - RW region: `rw_regs` byte
  - RO region: `ro_snap` byte (addr-RW_LEN)
  - STAT: `err_cnt`
  - beyond STAT: 0x00
- `err_cnt` saturates at 255 and never wraps.

## Timing
- Reset values:
  - `rw_regs` = RW_INIT
  - `rw_wr_pulse` = 0, `err_cnt` = 0, `i2c_data_in` = 0
  - `ro_snap` = 0, `snap_valid` = 0, `addr_q` = 0, `done_q` = 1
- Rising edge of `done` sampled at edge N: `rw_regs`, `rw_wr_pulse` and `err_cnt` update at edge N+1. The pulse is low again at N+2.
- `i2c_data_in` has 1-cycle latency from the address and state. Read-after-write to the same byte shows the new value from edge N+2.
- Snapshot trigger at edge N: `ro_snap` is valid at N+1, and `i2c_data_in` shows the RO base byte at N+2.
- Write and clear never coincide: exactly one action per event.
- Reset asserted mid-write: the write is lost and everything returns to reset values.

## Structure
- Package `i2c_reg_pkg` holds:
  - `I2C_DIR_WRITE`=1'b0, `I2C_DIR_READ`=1'b1
  - `I2C_ERR_W`=8, `I2C_ADDR_W`=8
- Sub-module `i2c_err_counter`: saturating counter with `inc`/`clr`; `clr` has priority; `mod_clk`/`rst_n`.
- Top-level integration swaps the inline register logic for `i2c_reg_bank`. Firmware version bytes connect to `ro_data`.

## Test plan
Defaults RW_LEN=10, RO_LEN=3.
- Reset: RW_INIT=80'h…0102 -> `rw_regs` byte0=0x02, byte1=0x01; `err_cnt`=0; `i2c_data_in`=0 until the first clock after reset.
- Write 0x5A to addr 3 with `done` held 4 cycles -> byte3=0x5A; `rw_wr_pulse`=10'b0000001000 for exactly one cycle; read of addr 3 returns 0x5A.
- wp=1, write 0x77 to addr 0 -> byte0 unchanged, no pulse, `err_cnt`=1. Write to addr 11 -> `err_cnt`=2. Write addr 13 (STAT) -> `err_cnt`=0.
- Snapshot coherence:
  - `ro_data`=24'h000100; move addr to 10 -> snapshot taken.
  - Change `ro_data` to 24'hFFFFFF.
  - Read 10, 11, 12 -> 0x00, 0x01, 0x00.
  - Leave and re-enter addr 10 -> reads 0xFF.
- 260 rejected writes -> `err_cnt` stays 255; STAT read returns 0xFF; addr 200 read returns 0x00.
- Reset pulsed with `done`=1 held through release -> no write and no pulse after release.
